// File: rtl/univ_shift_pkg.sv
// Shared types and next-bit helper for the universal shift register.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_LOAD = 3'd1,
    M_SHL  = 3'd2,
    M_SHR  = 3'd3,
    M_ROL  = 3'd4,
    M_ROR  = 3'd5,
    M_ASR  = 3'd6,
    M_CLR  = 3'd7
  } mode_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  function automatic logic is_shift(mode_e m);
    return (m inside {M_SHL, M_SHR, M_ROL, M_ROR, M_ASR});
  endfunction

  // lo/hi are the already-resolved bits arriving from below/above
  function automatic logic next_bit(
    mode_e m,
    logic  cur,
    logic  ld,
    logic  lo,
    logic  hi
  );
    logic r;
    r = cur;
    case (m)
      M_HOLD: r = cur;
      M_LOAD: r = ld;
      M_SHL,
      M_ROL:  r = lo;
      M_SHR,
      M_ROR,
      M_ASR:  r = hi;
      M_CLR:  r = 1'b0;
      default: r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/univ_shift_reg_dff.sv
// One-bit D flip-flop cell with synchronous
// active-high reset and enable.
module dff_sync_reset_en #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RST_BIT;
    else if (en) q <= d;
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with counted
// burst engine (start/busy/done).
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int            CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic [WIDTH-1:0] q_out,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  mode_e            op;
  mode_e            mode_in;
  logic [CNT_W-1:0] n_sat;
  logic [WIDTH-1:0] q;

  assign mode_in = mode_e'(mode);
  assign n_sat   = (shift_cnt > CNT_W'(WIDTH))
                 ? CNT_W'(WIDTH) : shift_cnt;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    op      = M_HOLD;
    unique case (state_q)
      S_IDLE: begin
        if (start && is_shift(mode_in)) begin
          // accepting edge performs no operation
          if (n_sat == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode_in;
            cnt_d   = n_sat;
            state_d = S_BURST;
          end
        end else begin
          op = mode_in;
        end
      end
      S_BURST: begin
        op    = mode_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic lo, hi, nb;
      if (i == 0) begin : g_lo_edge
        assign lo = (op == M_ROL) ? q[WIDTH-1] : ser_in_l;
      end else begin : g_lo_mid
        assign lo = q[i-1];
      end
      if (i == WIDTH - 1) begin : g_hi_edge
        assign hi = (op == M_ROR) ? q[0]
                  : (op == M_ASR) ? q[WIDTH-1]
                  : ser_in_r;
      end else begin : g_hi_mid
        assign hi = q[i+1];
      end
      assign nb = next_bit(op, q[i], d_in[i], lo, hi);
      dff_sync_reset_en #(
        .RST_BIT (RESET_VAL[i])
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .en    (op != M_HOLD),
        .d     (nb),
        .q     (q[i])
      );
    end
  endgenerate

  assign q_out     = q;
  assign ser_out_l = q[WIDTH-1];
  assign ser_out_r = q[0];
  assign busy      = (state_q == S_BURST);
  assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg
// (WIDTH=8, RESET_VAL=8'hA5).
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    mode;
  logic [W-1:0]  d_in;
  logic          ser_in_l, ser_in_r, start;
  logic [CW-1:0] shift_cnt;
  logic [W-1:0]  q_out;
  logic          ser_out_l, ser_out_r, busy, done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(
    .WIDTH     (W),
    .RESET_VAL (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .d_in      (d_in),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .start     (start),
    .shift_cnt (shift_cnt),
    .q_out     (q_out),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    mode  = 3'd1;
    d_in  = v;
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mode      = 3'($urandom_range(0, 7));
      d_in      = 8'($urandom);
      ser_in_l  = 1'($urandom);
      ser_in_r  = 1'($urandom);
      start     = 1'($urandom);
      shift_cnt = 4'($urandom);
      tick();
    end
    vectors++;
    if ({q_out, busy, done} !== {8'hA5, 2'b00}) begin
      miscompares++;
      $display("FAIL reset: q=%h busy=%b done=%b want A5 0 0",
               q_out, busy, done);
    end
    vectors++;
    if ({ser_out_l, ser_out_r} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ser: got %b%b want 11",
               ser_out_l, ser_out_r);
    end
    reset = 1'b0;
    start = 1'b0;
    mode  = 3'd7;
    tick();
    vectors++;
    if (q_out !== 8'h00) begin
      miscompares++;
      $display("FAIL clr: q=%h want 00", q_out);
    end
    reset = 1'b1;
    mode  = 3'd0;
    tick();
    vectors++;
    if (q_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL rereset: q=%h want A5", q_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_ops();
    logic [2:0] ops [5] = '{3'd4, 3'd5, 3'd6, 3'd3, 3'd2};
    logic [7:0] exp [5] = '{8'h03, 8'hC0, 8'hC0, 8'h40, 8'h03};
    ser_in_l = 1'b1;
    ser_in_r = 1'b0;
    for (int k = 0; k < 5; k++) begin
      load(8'h81);
      mode = ops[k];
      tick();
      vectors++;
      if (q_out !== exp[k]) begin
        miscompares++;
        $display("FAIL single_op%0d: q=%h want %h",
                 ops[k], q_out, exp[k]);
      end
    end
    mode = 3'd0;
    tick();
    tick();
    vectors++;
    if (q_out !== 8'h03) begin
      miscompares++;
      $display("FAIL hold: q=%h want 03", q_out);
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp [3] = '{8'h02, 8'h04, 8'h08};
    load(8'h01);
    mode      = 3'd2;
    ser_in_l  = 1'b0;
    shift_cnt = 4'd3;
    start     = 1'b1;
    tick();
    vectors++;
    if ({q_out, busy, done} !== {8'h01, 2'b10}) begin
      miscompares++;
      $display("FAIL burst_start: q=%h busy=%b done=%b want 01 1 0",
               q_out, busy, done);
    end
    start = 1'b0;
    mode  = 3'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({q_out, busy, done} !==
          {exp[k], (k < 2), (k == 2)}) begin
        miscompares++;
        $display("FAIL burst_shift%0d: q=%h busy=%b done=%b want %h",
                 k + 1, q_out, busy, done, exp[k]);
      end
    end
    tick();
    vectors++;
    if ({q_out, busy, done} !== {8'h08, 2'b00}) begin
      miscompares++;
      $display("FAIL burst_after: q=%h busy=%b done=%b want 08 0 0",
               q_out, busy, done);
    end
  endtask

  task automatic test_edge_counts();
    mode      = 3'd2;
    shift_cnt = 4'd0;
    start     = 1'b1;
    tick();
    vectors++;
    if ({q_out, busy, done} !== {8'h08, 2'b01}) begin
      miscompares++;
      $display("FAIL n0: q=%h busy=%b done=%b want 08 0 1",
               q_out, busy, done);
    end
    start = 1'b0;
    mode  = 3'd0;
    tick();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL n0_after: busy=%b done=%b want 0 0",
               busy, done);
    end
    load(8'h00);
    mode      = 3'd3;
    ser_in_r  = 1'b1;
    shift_cnt = 4'd15;
    start     = 1'b1;
    tick();
    start = 1'b0;
    mode  = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      vectors++;
      if ({busy, done} !== 2'b10) begin
        miscompares++;
        $display("FAIL sat_busy%0d: busy=%b done=%b want 1 0",
                 k, busy, done);
      end
    end
    tick();
    vectors++;
    if ({q_out, busy, done} !== {8'hFF, 2'b01}) begin
      miscompares++;
      $display("FAIL sat_end: q=%h busy=%b done=%b want FF 0 1",
               q_out, busy, done);
    end
  endtask

  task automatic test_reset_mid_burst();
    load(8'h81);
    mode      = 3'd4;
    shift_cnt = 4'd8;
    start     = 1'b1;
    tick();
    start = 1'b0;
    mode  = 3'd0;
    repeat (3) tick();
    vectors++;
    if ({q_out, busy} !== {8'h0C, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_pre: q=%h busy=%b want 0C 1",
               q_out, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({q_out, busy, done} !== {8'hA5, 2'b00}) begin
      miscompares++;
      $display("FAIL mid_reset: q=%h busy=%b done=%b want A5 0 0",
               q_out, busy, done);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if ({q_out, busy, done} !== {8'hA5, 2'b00}) begin
        miscompares++;
        $display("FAIL mid_quiet%0d: q=%h busy=%b done=%b want A5 0 0",
                 k, q_out, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    mode      = 3'd2;
    ser_in_l  = 1'b1;
    shift_cnt = 4'd2;
    start     = 1'b1;
    tick();
    mode = 3'd1;
    d_in = 8'hFF;
    tick();
    vectors++;
    if ({q_out, busy, done} !== {8'h03, 2'b10}) begin
      miscompares++;
      $display("FAIL ign_1: q=%h busy=%b done=%b want 03 1 0",
               q_out, busy, done);
    end
    tick();
    vectors++;
    if ({q_out, busy, done} !== {8'h07, 2'b01}) begin
      miscompares++;
      $display("FAIL ign_2: q=%h busy=%b done=%b want 07 0 1",
               q_out, busy, done);
    end
    mode      = 3'd3;
    ser_in_r  = 1'b0;
    shift_cnt = 4'd2;
    start     = 1'b1;
    tick();
    vectors++;
    if ({q_out, busy, done} !== {8'h07, 2'b10}) begin
      miscompares++;
      $display("FAIL b2b_acc: q=%h busy=%b done=%b want 07 1 0",
               q_out, busy, done);
    end
    start = 1'b0;
    mode  = 3'd0;
    tick();
    tick();
    vectors++;
    if ({q_out, busy, done} !== {8'h01, 2'b01}) begin
      miscompares++;
      $display("FAIL b2b_end: q=%h busy=%b done=%b want 01 0 1",
               q_out, busy, done);
    end
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 3'd0;
    d_in      = '0;
    ser_in_l  = 1'b0;
    ser_in_r  = 1'b0;
    start     = 1'b0;
    shift_cnt = '0;
    #2;
    test_reset();
    test_single_ops();
    test_burst();
    test_edge_counts();
    test_reset_mid_burst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
